// File: rtl/uart_dump_trigger.sv
// -----------------------------------------------------------------------------
// uart_dump_trigger
//
// Front end for the memory UART dumper. It receives 8N1 serial bytes on rx and
// watches a debounced push-button. When a command byte or a button press
// arrives and the dumper is idle, it issues a single-cycle start_dump pulse.
// Received bytes, a sticky framing-error flag and the trigger/drop counters are
// brought out for debug LEDs.
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous, active-high
//   rx                asynchronous UART line, idle high
//   btn               asynchronous raw push-button, active high
//   dump_in_progress  busy flag from the dumper
//   start_dump        one-cycle dump request pulse
//   rx_byte           last byte received with a valid stop bit
//   rx_valid          one-cycle pulse, rx_byte updated in the same cycle
//   frame_error       sticky bad-stop-bit flag, cleared only by reset
//   trigger_count     start_dump pulses issued (wraps)
//   drop_count        requests rejected by lockout (wraps)
//
// RX FSM states
//   state   | meaning
//   S_IDLE  | line idle, waiting for a falling edge on rx_s
//   S_START | timing to mid start bit to confirm it is not a glitch
//   S_DATA  | sampling 8 data bits at mid-bit, LSB first
//   S_STOP  | sampling the stop bit, then report byte or framing error
// -----------------------------------------------------------------------------
module uart_dump_trigger #(
    parameter int          CLK_FREQ_HZ     = 50_000_000,
    parameter int          BAUD_RATE       = 115200,
    parameter logic [7:0]  CMD_CHAR        = 8'h44,
    parameter int          DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       btn,
    input  logic       dump_in_progress,
    output logic       start_dump,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_error,
    output logic [7:0] trigger_count,
    output logic [7:0] drop_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int DEB_W        = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ------------------------------------------------------------------------
    // Input synchronizers, reset to the idle line levels
    // ------------------------------------------------------------------------
    logic rx_meta, rx_s;
    logic btn_meta, btn_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

    // ------------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------------
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        if (rx_s) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Button debounce: the level only follows btn_s after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles. btn_rise marks an accepted press.
    // ------------------------------------------------------------------------
    logic             btn_deb;
    logic [DEB_W-1:0] deb_cnt;
    logic             btn_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_deb  <= 1'b0;
            deb_cnt  <= '0;
            btn_rise <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            if (btn_s == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt  <= '0;
                btn_deb  <= btn_s;
                btn_rise <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Trigger and lockout. holdoff covers the gap between start_dump and the
    // dumper raising busy; it is released by the busy flag's falling edge.
    // ------------------------------------------------------------------------
    logic holdoff;
    logic dip_q;
    logic trig_req;
    logic locked;
    logic dip_fall;

    always_comb begin
        trig_req = (rx_valid && (rx_byte == CMD_CHAR)) || btn_rise;
        locked   = dump_in_progress || holdoff;
        dip_fall = dip_q && !dump_in_progress;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_dump    <= 1'b0;
            holdoff       <= 1'b0;
            dip_q         <= 1'b0;
            trigger_count <= '0;
            drop_count    <= '0;
        end else begin
            dip_q      <= dump_in_progress;
            start_dump <= 1'b0;
            if (trig_req && !locked) begin
                start_dump    <= 1'b1;
                trigger_count <= trigger_count + 8'd1;
                holdoff       <= 1'b1;
            end else begin
                if (trig_req) begin
                    drop_count <= drop_count + 8'd1;
                end
                if (dip_fall) begin
                    holdoff <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_dump_trigger.sv
// -----------------------------------------------------------------------------
// tb_uart_dump_trigger
//
// Directed bench for uart_dump_trigger at the default 50 MHz / 115200 baud
// (434 clocks per bit) with a 16-cycle debounce. Stimulus changes on the
// falling clock edge; outputs are sampled on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_uart_dump_trigger;

    localparam int CPB = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       btn;
    logic       dip;
    logic       start_dump;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_error;
    logic [7:0] trigger_count;
    logic [7:0] drop_count;

    uart_dump_trigger #(
        .CLK_FREQ_HZ     (50_000_000),
        .BAUD_RATE       (115200),
        .CMD_CHAR        (8'h44),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx               (rx),
        .btn              (btn),
        .dump_in_progress (dip),
        .start_dump       (start_dump),
        .rx_byte          (rx_byte),
        .rx_valid         (rx_valid),
        .frame_error      (frame_error),
        .trigger_count    (trigger_count),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor: counts rx_valid / start_dump cycles and records when.
    int cyc       = 0;
    int n_valid   = 0;
    int n_start   = 0;
    int valid_cyc = 0;
    int start_cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_valid) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (start_dump) begin
            n_start   = n_start + 1;
            start_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A bad stop bit is held low for only 3/4 of a bit so the line is high
    // again before the receiver's next start-bit check.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_ok;
        idle(stop_ok ? CPB : (3 * CPB) / 4);
        rx = 1'b1;
        if (!stop_ok) idle(CPB - (3 * CPB) / 4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        btn   = 1'b0;
        dip   = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(2);
    endtask

    int v0, s0;
    logic [7:0] partial;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        btn   = 1'b0;
        dip   = 1'b0;
        idle(4);

        // Reset state
        check_eq("rst_start_dump", start_dump, 1'b0);
        check_eq("rst_rx_byte",    rx_byte, 8'h00);
        check_eq("rst_rx_valid",   rx_valid, 1'b0);
        check_eq("rst_frame_err",  frame_error, 1'b0);
        check_eq("rst_trig_cnt",   trigger_count, 8'd0);
        check_eq("rst_drop_cnt",   drop_count, 8'd0);
        reset = 1'b0;
        idle(2);

        // Command accepted
        v0 = n_valid; s0 = n_start;
        send_byte(8'h44, 1'b1);
        idle(5);
        check_eq("cmd_valid_pulses", n_valid - v0, 1);
        check_eq("cmd_rx_byte",      rx_byte, 8'h44);
        check_eq("cmd_start_pulses", n_start - s0, 1);
        check_eq("cmd_latency",      start_cyc - valid_cyc, 1);
        check_eq("cmd_trig_cnt",     trigger_count, 8'd1);
        check_eq("cmd_drop_cnt",     drop_count, 8'd0);

        // Holdoff window: second command back-to-back, before busy rises
        v0 = n_valid; s0 = n_start;
        send_byte(8'h44, 1'b1);
        idle(5);
        check_eq("hold_valid_pulses", n_valid - v0, 1);
        check_eq("hold_start_pulses", n_start - s0, 0);
        check_eq("hold_drop_cnt",     drop_count, 8'd1);
        check_eq("hold_trig_cnt",     trigger_count, 8'd1);
        // Busy cycle from the dumper releases holdoff on its falling edge
        dip = 1'b1; idle(10); dip = 1'b0; idle(5);
        s0 = n_start;
        send_byte(8'h44, 1'b1);
        idle(5);
        check_eq("rel_start_pulses", n_start - s0, 1);
        check_eq("rel_trig_cnt",     trigger_count, 8'd2);

        // Lockout drop while the dumper is busy
        do_reset();
        dip = 1'b1;
        idle(5);
        s0 = n_start;
        send_byte(8'h44, 1'b1);
        idle(5);
        check_eq("lock_start_pulses", n_start - s0, 0);
        check_eq("lock_drop_cnt",     drop_count, 8'd1);
        check_eq("lock_trig_cnt",     trigger_count, 8'd0);
        dip = 1'b0;
        idle(10);
        send_byte(8'h44, 1'b1);
        idle(5);
        check_eq("unlock_start_pulses", n_start - s0, 1);
        check_eq("unlock_trig_cnt",     trigger_count, 8'd1);

        // Framing error, then a valid non-command byte
        v0 = n_valid;
        send_byte(8'h5A, 1'b0);
        idle(5);
        check_eq("ferr_flag",         frame_error, 1'b1);
        check_eq("ferr_valid_pulses", n_valid - v0, 0);
        check_eq("ferr_rx_byte",      rx_byte, 8'h44);
        idle(CPB);
        s0 = n_start;
        send_byte(8'h41, 1'b1);
        idle(5);
        check_eq("after_ferr_valid", n_valid - v0, 1);
        check_eq("after_ferr_byte",  rx_byte, 8'h41);
        check_eq("after_ferr_flag",  frame_error, 1'b1);
        check_eq("noncmd_start",     n_start - s0, 0);
        check_eq("noncmd_trig_cnt",  trigger_count, 8'd1);
        check_eq("noncmd_drop_cnt",  drop_count, 8'd1);

        // Reset during the 4th data bit of 0x44
        partial = 8'h44;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            idle(CPB);
        end
        rx = partial[3];
        idle(CPB / 2);
        reset = 1'b1;
        rx    = 1'b1;
        idle(2);
        check_eq("midrst_rx_byte",   rx_byte, 8'h00);
        check_eq("midrst_frame_err", frame_error, 1'b0);
        check_eq("midrst_trig_cnt",  trigger_count, 8'd0);
        check_eq("midrst_drop_cnt",  drop_count, 8'd0);
        check_eq("midrst_start",     start_dump, 1'b0);
        check_eq("midrst_state",     dut.state, 2'd0);
        reset = 1'b0;
        v0 = n_valid;
        idle(CPB);
        send_byte(8'h44, 1'b1);
        idle(5);
        check_eq("postrst_valid",    n_valid - v0, 1);
        check_eq("postrst_rx_byte",  rx_byte, 8'h44);
        check_eq("postrst_trig_cnt", trigger_count, 8'd1);
        check_eq("postrst_frame_err", frame_error, 1'b0);

        // Glitch rejection: 100-cycle low pulse, shorter than half a bit
        do_reset();
        v0 = n_valid;
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(2 * CPB);
        check_eq("glitch_valid",     n_valid - v0, 0);
        check_eq("glitch_frame_err", frame_error, 1'b0);
        check_eq("glitch_state",     dut.state, 2'd0);

        // Button debounce: bounce every 5 cycles, then hold high 40 cycles
        do_reset();
        s0 = n_start;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            idle(5);
        end
        check_eq("bounce_no_start", n_start - s0, 0);
        btn = 1'b1;
        idle(40);
        btn = 1'b0;
        idle(40);
        check_eq("btn_start_pulses", n_start - s0, 1);
        check_eq("btn_trig_cnt",     trigger_count, 8'd1);
        check_eq("btn_drop_cnt",     drop_count, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
